// File: rtl/sme_loader_if.sv
// Byte-stream ingress and matcher-facing burst signals of the string-matching loader.
interface sme_loader_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_is_pattern;
    logic       in_last;
    logic       sme_valid;
    logic [7:0] chardata;
    logic       isstring;
    logic       ispattern;
    logic [4:0] pat_id;
    logic       ovf;
    logic       nostr;

    modport master (
        output in_valid, in_data, in_is_pattern, in_last, sme_valid,
        input  in_ready, chardata, isstring, ispattern, pat_id, ovf, nostr
    );

    modport slave (
        input  in_valid, in_data, in_is_pattern, in_last, sme_valid,
        output in_ready, chardata, isstring, ispattern, pat_id, ovf, nostr
    );
endinterface

// File: rtl/sme_loader.sv
// Buffers a whole string/pattern record, then replays it as an unbroken burst to the matcher.
// Burst starts the cycle after the final beat; in_ready is low during the burst and until the matcher's result after a pattern.
module sme_loader #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8
) (
    input logic         clk,
    input logic         reset,
    sme_loader_if.slave bus
);
    localparam int AW = $clog2(STR_MAX);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] STR_LIM = LW'(STR_MAX);
    localparam logic [LW-1:0] PAT_LIM = LW'(PAT_MAX);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;

    state_t        state_q;
    logic          is_pat_q;
    logic          str_loaded_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] idx_q;
    logic [7:0]    buf_q [STR_MAX];
    logic [4:0]    pat_id_q;
    logic [7:0]    chardata_q;
    logic          isstring_q;
    logic          ispattern_q;
    logic          ovf_q;
    logic          nostr_q;
    logic          in_ready_q;

    logic          acc;
    logic [LW-1:0] limit;
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic          done;
    logic          done_pat;
    logic [7:0]    first_byte;

    assign acc        = bus.in_valid && in_ready_q;
    assign limit      = is_pat_q ? PAT_LIM : STR_LIM;
    // The record type comes from the first beat, which in IDLE is still on the bus.
    assign done       = acc && bus.in_last && (state_q == IDLE || state_q == LOAD);
    assign done_pat   = (state_q == IDLE) ? bus.in_is_pattern : is_pat_q;
    assign first_byte = (state_q == IDLE) ? bus.in_data : buf_q[0];

    always_comb begin
        wr_en  = 1'b0;
        wr_idx = '0;
        if (acc && state_q == IDLE) begin
            wr_en = 1'b1;
        end else if (acc && state_q == LOAD && len_q < limit) begin
            wr_en  = 1'b1;
            wr_idx = len_q[AW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_q[wr_idx] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            is_pat_q     <= 1'b0;
            str_loaded_q <= 1'b0;
            len_q        <= '0;
            idx_q        <= '0;
            pat_id_q     <= '0;
            chardata_q   <= '0;
            isstring_q   <= 1'b0;
            ispattern_q  <= 1'b0;
            ovf_q        <= 1'b0;
            nostr_q      <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            ovf_q   <= 1'b0;
            nostr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (acc) begin
                        is_pat_q <= bus.in_is_pattern;
                        len_q    <= LW'(1);
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    if (acc) begin
                        if (len_q < limit) begin
                            len_q <= len_q + LW'(1);
                        end else begin
                            ovf_q <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (idx_q < len_q) begin
                        chardata_q <= buf_q[idx_q[AW-1:0]];
                        idx_q      <= idx_q + LW'(1);
                    end else begin
                        chardata_q  <= '0;
                        isstring_q  <= 1'b0;
                        ispattern_q <= 1'b0;
                        in_ready_q  <= !is_pat_q;
                        state_q     <= is_pat_q ? WAIT : IDLE;
                    end
                end
                WAIT: begin
                    if (bus.sme_valid) begin
                        pat_id_q   <= (pat_id_q == 5'd31) ? pat_id_q : pat_id_q + 5'd1;
                        in_ready_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (done) begin
                if (!done_pat || str_loaded_q) begin
                    if (!done_pat) begin
                        pat_id_q     <= '0;
                        str_loaded_q <= 1'b1;
                    end
                    is_pat_q    <= done_pat;
                    state_q     <= SEND;
                    in_ready_q  <= 1'b0;
                    chardata_q  <= first_byte;
                    isstring_q  <= !done_pat;
                    ispattern_q <= done_pat;
                    idx_q       <= LW'(1);
                end else begin
                    nostr_q    <= 1'b1;
                    len_q      <= '0;
                    in_ready_q <= 1'b1;
                    state_q    <= IDLE;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.chardata  = chardata_q;
    assign bus.isstring  = isstring_q;
    assign bus.ispattern = ispattern_q;
    assign bus.pat_id    = pat_id_q;
    assign bus.ovf       = ovf_q;
    assign bus.nostr     = nostr_q;
endmodule

// File: tb/tb_sme_loader.sv
// Record-level bench for sme_loader: table vectors, hand corner sequences and random records vs a model.
module tb_sme_loader;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sme_loader_if bus();
    sme_loader #(.STR_MAX(32), .PAT_MAX(8)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        int         cyc;
        bit         pat;
        logic [7:0] dat;
    } beat_t;

    typedef struct {
        string txt;
        bit    is_pat;
        int    gap;
        int    e_len;
        int    e_ovf;
        int    e_nostr;
        int    e_pid;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc_cnt = 0;
    int          ovf_cnt = 0;
    int          nostr_cnt = 0;
    int          both_cnt = 0;
    int          dirty_cnt = 0;
    beat_t       cap[$];
    bit          rdy_hist [0:8191];
    logic [7:0]  rec_dat [0:63];
    bit          m_str;
    int          m_pid;
    string       tag;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Label of the cycle following edge N is N+1.
    always @(negedge clk) begin
        rdy_hist[(cyc_cnt + 1) % 8192] <= bus.in_ready;
        if (bus.ovf)   ovf_cnt   <= ovf_cnt + 1;
        if (bus.nostr) nostr_cnt <= nostr_cnt + 1;
        if (bus.isstring && bus.ispattern) both_cnt <= both_cnt + 1;
        if (!bus.isstring && !bus.ispattern && bus.chardata != 8'd0) dirty_cnt <= dirty_cnt + 1;
        if (bus.isstring || bus.ispattern)
            cap.push_back(beat_t'{cyc: cyc_cnt + 1, pat: bus.ispattern, dat: bus.chardata});
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s %s: got %0d expected %0d", tag, nm, act, exp);
        end
    endtask

    task automatic nstep;
        @(negedge clk);
        #1;
    endtask

    task automatic drive_beats(input int n, input bit is_pat, input int gap, output int t_acc);
        int tries;
        t_acc = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    bus.in_valid = 1'b0;
                    bus.in_data  = 8'($urandom);
                    nstep;
                end
            end
            bus.in_valid      = 1'b1;
            bus.in_data       = rec_dat[i];
            bus.in_last       = (i == n - 1);
            bus.in_is_pattern = (i == 0) ? is_pat : 1'($urandom_range(0, 1));
            tries = 0;
            while (!bus.in_ready && tries < 200) begin
                nstep;
                tries++;
            end
            if (!bus.in_ready) chk("accept_timeout", 0, 1);
            t_acc = cyc_cnt + 1;
            nstep;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic do_rec(input int n, input bit is_pat, input int gap,
                          input int e_len, input int e_ovf, input int e_nostr, input int e_pid);
        int t, base, ob, nb, obs_len, bad;
        base = cap.size();
        ob   = ovf_cnt;
        nb   = nostr_cnt;
        drive_beats(n, is_pat, gap, t);
        repeat (34) nstep;
        obs_len = cap.size() - base;
        chk("burst_len", obs_len, e_len);
        bad = 0;
        for (int i = 0; i < obs_len; i++) begin
            if (cap[base + i].cyc != t + 1 + i || cap[base + i].pat != is_pat ||
                cap[base + i].dat != rec_dat[i]) bad++;
        end
        if (e_len > 0) chk("burst_beats_bad", bad, 0);
        chk("ovf_pulses", ovf_cnt - ob, e_ovf);
        chk("nostr_pulses", nostr_cnt - nb, e_nostr);
        if (e_nostr != 0) begin
            chk("nostr_ready", int'(rdy_hist[(t + 1) % 8192]), 1);
        end else if (!is_pat) begin
            chk("ready_in_burst_end", int'(rdy_hist[(t + e_len) % 8192]), 0);
            chk("ready_after_str", int'(rdy_hist[(t + e_len + 1) % 8192]), 1);
        end else begin
            chk("wait_start_ready", int'(rdy_hist[(t + e_len + 1) % 8192]), 0);
            repeat ($urandom_range(0, 3)) nstep;
            chk("wait_hold", int'(bus.in_ready), 0);
            chk("wait_quiet", int'({bus.isstring, bus.ispattern, bus.chardata}), 0);
            bus.sme_valid = 1'b1;
            nstep;
            bus.sme_valid = 1'b0;
            chk("wait_release", int'(bus.in_ready), 1);
        end
        chk("pat_id", int'(bus.pat_id), e_pid);
    endtask

    task automatic model_rec(input int n, input bit is_pat,
                             output int e_len, output int e_ovf, output int e_nostr, output int e_pid);
        int lim;
        lim     = is_pat ? 8 : 32;
        e_len   = (n < lim) ? n : lim;
        e_ovf   = n - e_len;
        e_nostr = 0;
        if (!is_pat) begin
            m_str = 1'b1;
            m_pid = 0;
        end else if (m_str) begin
            m_pid = (m_pid < 31) ? m_pid + 1 : 31;
        end else begin
            e_nostr = 1;
            e_len   = 0;
        end
        e_pid = m_pid;
    endtask

    task automatic model_run(input int n, input bit is_pat, input int gap);
        int el, eo, en, ep;
        model_rec(n, is_pat, el, eo, en, ep);
        do_rec(n, is_pat, gap, el, eo, en, ep);
    endtask

    vec_t vt [9];

    initial begin
        int t, el, eo, en, ep, n;
        bit p;

        vt[0] = '{"ab",         1'b1, 0, 0,  0, 1, 0};
        vt[1] = '{"abc de",     1'b0, 0, 6,  0, 0, 0};
        vt[2] = '{"de",         1'b1, 0, 2,  0, 0, 1};
        vt[3] = '{"hello",      1'b0, 3, 5,  0, 0, 0};
        vt[4] = '{"0123456789", 1'b1, 0, 8,  2, 0, 1};
        vt[5] = '{"x",          1'b1, 1, 1,  0, 0, 2};
        vt[6] = '{"yz",         1'b1, 2, 2,  0, 0, 3};
        vt[7] = '{"abcdefghijklmnopqrstuvwxyzABCDEFG", 1'b0, 0, 32, 1, 0, 0};
        vt[8] = '{"abcdefgh",   1'b1, 0, 8,  0, 0, 1};

        tag = "reset";
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = 8'd0; bus.in_is_pattern = 1'b0;
        bus.in_last = 1'b0; bus.sme_valid = 1'b0;
        m_str = 1'b0; m_pid = 0;
        repeat (3) nstep;
        chk("ready_in_reset", int'(bus.in_ready), 0);
        chk("outs_in_reset", int'({bus.chardata, bus.isstring, bus.ispattern, bus.pat_id, bus.ovf, bus.nostr}), 0);
        reset = 1'b0;
        nstep;
        chk("ready_after_release", int'(bus.in_ready), 1);

        for (int v = 0; v < 9; v++) begin
            tag = $sformatf("vec%0d", v);
            for (int j = 0; j < vt[v].txt.len(); j++) rec_dat[j] = vt[v].txt[j];
            model_rec(vt[v].txt.len(), vt[v].is_pat, el, eo, en, ep);
            do_rec(vt[v].txt.len(), vt[v].is_pat, vt[v].gap,
                   vt[v].e_len, vt[v].e_ovf, vt[v].e_nostr, vt[v].e_pid);
        end

        tag = "spurious";
        bus.sme_valid = 1'b1;
        nstep;
        bus.sme_valid = 1'b0;
        nstep;
        chk("pat_id_kept", int'(bus.pat_id), m_pid);
        chk("ready_kept", int'(bus.in_ready), 1);
        rec_dat[0] = 8'h71;
        model_run(1, 1'b1, 0);

        tag = "rst_send";
        for (int j = 0; j < 6; j++) rec_dat[j] = 8'(8'h30 + j);
        drive_beats(6, 1'b0, 0, t);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("send_active", int'(bus.isstring), 1);
        reset = 1'b1;
        #1;
        chk("rst_async_outs", int'({bus.chardata, bus.isstring, bus.ispattern, bus.pat_id}), 0);
        chk("rst_async_ready", int'(bus.in_ready), 0);
        nstep;
        reset = 1'b0;
        m_str = 1'b0;
        m_pid = 0;
        nstep;
        rec_dat[0] = 8'h61; rec_dat[1] = 8'h62;
        model_run(2, 1'b1, 0);

        tag = "saturate";
        for (int j = 0; j < 3; j++) rec_dat[j] = 8'(8'h41 + j);
        model_run(3, 1'b0, 0);
        for (int k = 0; k < 33; k++) begin
            rec_dat[0] = 8'(k);
            model_run(1, 1'b1, 0);
        end

        for (int r = 0; r < 30; r++) begin
            tag = $sformatf("rand%0d", r);
            p = ($urandom_range(0, 2) != 0);
            n = p ? $urandom_range(1, 11) : $urandom_range(1, 35);
            for (int j = 0; j < n; j++) rec_dat[j] = 8'($urandom);
            model_run(n, p, $urandom_range(0, 2));
        end

        tag = "global";
        chk("both_flags_cycles", both_cnt, 0);
        chk("idle_data_cycles", dirty_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
